rr_rob_commit: RTL
==================

# rr_rob_commit

Reorder-buffer commit source for the register-rename (RR) stage. Accepts up to two in-order allocations per cycle from issue, marks entries complete from EX updates, and retires one entry per cycle in program order. Each retirement is a `writeback_toARF` commit carrying `flushed`, `ldst`, `pdst` and `ppdst`. The rename stage uses this commit stream to free `ppdst`, or to release `pdst` when the entry was flushed. It is the producer side of the commit interface that the RR stage consumes.

## Interface
Parameters:
- `ROB_INDEX_BITS`, 3, ticket width; depth = 2**ROB_INDEX_BITS = 8.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `new_req_i` in `new_entries` (114): up to two allocation requests per cycle; slot 1 is older than slot 2.
- `ex_upd_i` in `ex_update` (47): completion from EX, indexed by `ticket`.
- `flush_i` in 1: branch miss.
- `flush_ticket_i` in 3: ticket of the mispredicted branch.
- `commit_ready_i` in 1: RR stage accepts the commit this cycle.
- `commit_o` out `writeback_toARF` (88): head-entry commit.
- `issue_o` out `to_issue` (5): `is_full`, `two_empty`, `ticket` (next ticket, i.e. the tail index).

## Operation
- Storage: 8 entries, each holding `valid`, `pending`, `flushed`, `valid_dest`, `lreg`, `preg`, `ppreg`, `microoperation`, `pc` and a 32-bit `data`.
- Pointers: 3-bit `head` and `tail`, both wrapping modulo 8; 4-bit `count` in the range 0..8.
- Allocation:
  - `valid_request_1` writes entry `tail` with `valid`=1, `pending`=1, `flushed`=0.
  - `valid_request_2` writes entry `tail+1` if slot 1 is also valid, otherwise entry `tail`.
  - `tail` advances by the number of valid requests.
  - `valid_request_2` without `valid_request_1` is legal and is treated as a single request.
- Capacity:
  - `is_full` = (`count`==8); `two_empty` = (`count`<=6). Both are computed from the registered `count`; a same-cycle commit is not credited.
  - Issue must not present more requests than the flags allow.
  - A request that exceeds capacity is dropped and fires a simulation assertion.
- EX update:
  - When `ex_upd_i.valid`, the entry at `ticket` is valid and that entry is not flushed, clear `pending` and store `data`.
  - Updates to invalid or flushed entries are ignored.
  - `valid_exception` and `cause` are reserved and ignored.
- Flush:
  - On `flush_i`, every valid entry strictly younger than `flush_ticket_i` gets `flushed`=1 and `pending`=0. "Younger" means index (`flush_ticket_i`+1) up to (`tail`-1), modulo 8.
  - The branch entry itself is untouched.
  - Flushed entries are not removed early; they still retire in order.
- Commit:
  - `commit_o.valid_commit` = `valid[head]` & !`pending[head]`.
  - `commit_o.flushed` = `flushed[head]`.
  - `commit_o.valid_write` = `valid_dest[head]` & !`flushed[head]`.
  - `ldst`/`pdst`/`ppdst` = `lreg`/`preg`/`ppreg`; `data`, `pc` and `ticket`=`head` come from the head entry.
  - When `valid_commit` is 0, all `commit_o` fields are 0.
  - The commit fires when `valid_commit` & `commit_ready_i`. On fire, clear `valid[head]` and advance `head`.
- Count update: `count` += accepted allocations − fire.
- Simultaneous events:
  - A flush and an EX update to the same younger entry in one cycle: the flush wins; the entry is flushed and `data` is not written.
  - Allocations in the flush cycle are never marked flushed.

## Timing
- Reset values (asynchronous, held while `rst_n`=0):
  - All entries invalid; `head`=`tail`=`count`=0.
  - `issue_o` = {`is_full`=0, `two_empty`=1, `ticket`=0}.
  - `commit_o` = all zeros.
- `commit_o` is combinational from head state; `commit_ready_i` does not feed back into `commit_o`.
- Latency:
  - Allocation at edge N is reflected in `issue_o` in cycle N+1.
  - The earliest possible sequence is: allocate at edge N, EX update at edge N+1, `valid_commit`=1 during cycle N+1→N+2.
- Commit handshake: `valid_commit` stays asserted with stable fields until fire.
- Throughput: at most 1 commit per cycle.
- Pointer wrap: 7→0 without a bubble.
- Flush latency: the flush takes effect at the edge where `flush_i` is sampled; the affected entries show `flushed`=1 from the next cycle.
- `rst_n` asserted mid-operation discards all entries immediately; no commit is emitted.

## Test plan
- Reset: drive `rst_n`=0, then release → `issue_o`={0,1,0}, `commit_o.valid_commit`=0, and no commit for 10 idle cycles.
- Fill: four cycles of dual allocation →
  - `issue_o.ticket` sequence 0,2,4,6,0.
  - `two_empty`=0 once `count`=8; `is_full`=1.
  - A third request offered while full is dropped and the assertion fires.
- Out-of-order completion: allocate tickets 0..3; EX updates tickets 3,2,1 with data 0x33,0x22,0x11, then ticket 0 with 0x00 → commits for tickets 0,1,2,3 on four consecutive cycles with matching data and `ppdst`.
- Flush: allocate tickets 0..5; `flush_i` with `flush_ticket_i`=2; then a later EX update to ticket 4 → tickets 3,4,5 retire with `flushed`=1, `valid_write`=0 and correct `pdst`; the ticket-4 update is ignored.
- Backpressure and wrap: random 50% `commit_ready_i` over more than 20 allocations → the ticket wraps 7→0; commit order is strict with no duplicates or losses. At `count`=7, one allocation plus one fire in the same cycle leaves `count`=7.
- `valid_dest`=0 entry: the entry commits with `valid_write`=0 and `flushed`=0, with `ldst`/`pdst`/`ppdst` still driven from the entry.

Source files
------------

// File: rtl/rr_rob_commit_if.sv
// Commit-source payload types and the bundle between the ROB and its issue/EX/RR neighbours.
// The package lives here so the types compile before both the interface and the ROB.
package rr_rob_pkg;

    parameter int unsigned RobIndexBits = 3;

    typedef struct packed {
        logic                    valid_request_1;
        logic                    valid_dest_1;
        logic [5:0]              lreg_1;
        logic [5:0]              preg_1;
        logic [5:0]              ppreg_1;
        logic [4:0]              microoperation_1;
        logic [31:0]             pc_1;
        logic                    valid_request_2;
        logic                    valid_dest_2;
        logic [5:0]              lreg_2;
        logic [5:0]              preg_2;
        logic [5:0]              ppreg_2;
        logic [4:0]              microoperation_2;
        logic [31:0]             pc_2;
    } new_entries;

    typedef struct packed {
        logic                    valid;
        logic                    valid_exception;
        logic [9:0]              cause;
        logic [RobIndexBits-1:0] ticket;
        logic [31:0]             data;
    } ex_update;

    typedef struct packed {
        logic                    valid_commit;
        logic                    valid_write;
        logic                    flushed;
        logic [5:0]              ldst;
        logic [5:0]              pdst;
        logic [5:0]              ppdst;
        logic [RobIndexBits-1:0] ticket;
        logic [31:0]             pc;
        logic [31:0]             data;
    } writeback_toARF;

    typedef struct packed {
        logic                    is_full;
        logic                    two_empty;
        logic [RobIndexBits-1:0] ticket;
    } to_issue;

endpackage

interface rr_rob_commit_if;
    import rr_rob_pkg::*;

    new_entries                  new_req_i;
    ex_update                    ex_upd_i;
    logic                        flush_i;
    logic [RobIndexBits-1:0]     flush_ticket_i;
    logic                        commit_ready_i;
    writeback_toARF              commit_o;
    to_issue                     issue_o;

    modport master (
        output new_req_i, ex_upd_i, flush_i, flush_ticket_i, commit_ready_i,
        input  commit_o, issue_o
    );

    modport slave (
        input  new_req_i, ex_upd_i, flush_i, flush_ticket_i, commit_ready_i,
        output commit_o, issue_o
    );
endinterface

// File: rtl/rr_rob_commit.sv
// Reorder buffer feeding the RR-stage commit stream: dual in-order allocate, EX completion,
// branch-miss flush marking and single in-order retirement per cycle.
module rr_rob_commit
    import rr_rob_pkg::*;
#(
    parameter int unsigned ROB_INDEX_BITS = rr_rob_pkg::RobIndexBits
) (
    input logic            clk,
    input logic            rst_n,
    rr_rob_commit_if.slave rob_if
);

    localparam int unsigned Depth = 1 << ROB_INDEX_BITS;
    localparam int unsigned CntW  = ROB_INDEX_BITS + 1;

    typedef logic [ROB_INDEX_BITS-1:0] idx_t;
    typedef logic [CntW-1:0]           cnt_t;

    logic [Depth-1:0] valid_q, valid_d, pending_q, pending_d;
    logic [Depth-1:0] flushed_q, flushed_d, vdest_q, vdest_d;
    logic [5:0]       lreg_q  [Depth];
    logic [5:0]       lreg_d  [Depth];
    logic [5:0]       preg_q  [Depth];
    logic [5:0]       preg_d  [Depth];
    logic [5:0]       ppreg_q [Depth];
    logic [5:0]       ppreg_d [Depth];
    logic [4:0]       uop_q   [Depth];
    logic [4:0]       uop_d   [Depth];
    logic [31:0]      pc_q    [Depth];
    logic [31:0]      pc_d    [Depth];
    logic [31:0]      data_q  [Depth];
    logic [31:0]      data_d  [Depth];
    idx_t             head_q, head_d, tail_q, tail_d;
    cnt_t             count_q, count_d;

    new_entries req;
    ex_update   ex;
    logic       req1, req2, acc1, acc2;
    cnt_t       free;
    idx_t       slot2_idx;
    logic       head_ready, fire;
    logic [Depth-1:0] flush_hit;
    idx_t       flush_span, flush_dist;
    logic [4:0] unused_uop;
    logic       unused_ex;

    assign req  = rob_if.new_req_i;
    assign ex   = rob_if.ex_upd_i;
    assign req1 = req.valid_request_1;
    assign req2 = req.valid_request_2;

    // Capacity uses the registered count only; a same-cycle retirement frees nothing yet.
    assign free      = cnt_t'(Depth) - count_q;
    assign acc1      = req1 && (free >= cnt_t'(1));
    assign acc2      = req2 && (free >= (req1 ? cnt_t'(2) : cnt_t'(1)));
    assign slot2_idx = tail_q + idx_t'(acc1);

    assign head_ready = valid_q[head_q] && !pending_q[head_q];
    assign fire       = head_ready && rob_if.commit_ready_i;

    // Younger than the branch: distance from flush_ticket+1 is below that of the tail.
    always_comb begin
        flush_hit  = '0;
        flush_dist = '0;
        flush_span = tail_q - rob_if.flush_ticket_i - idx_t'(1);
        for (int i = 0; i < Depth; i++) begin
            flush_dist = idx_t'(i) - rob_if.flush_ticket_i - idx_t'(1);
            if (rob_if.flush_i && valid_q[i] && (flush_dist < flush_span)) begin
                flush_hit[i] = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d   = valid_q;
        pending_d = pending_q;
        flushed_d = flushed_q;
        vdest_d   = vdest_q;
        lreg_d    = lreg_q;
        preg_d    = preg_q;
        ppreg_d   = ppreg_q;
        uop_d     = uop_q;
        pc_d      = pc_q;
        data_d    = data_q;
        head_d    = head_q;

        if (ex.valid && valid_q[ex.ticket] && !flushed_q[ex.ticket] && !flush_hit[ex.ticket]) begin
            pending_d[ex.ticket] = 1'b0;
            data_d[ex.ticket]    = ex.data;
        end

        for (int i = 0; i < Depth; i++) begin
            if (flush_hit[i]) begin
                flushed_d[i] = 1'b1;
                pending_d[i] = 1'b0;
            end
        end

        // New allocations land outside the flushed range and always start clean.
        if (acc1) begin
            valid_d[tail_q]   = 1'b1;
            pending_d[tail_q] = 1'b1;
            flushed_d[tail_q] = 1'b0;
            vdest_d[tail_q]   = req.valid_dest_1;
            lreg_d[tail_q]    = req.lreg_1;
            preg_d[tail_q]    = req.preg_1;
            ppreg_d[tail_q]   = req.ppreg_1;
            uop_d[tail_q]     = req.microoperation_1;
            pc_d[tail_q]      = req.pc_1;
            data_d[tail_q]    = '0;
        end
        if (acc2) begin
            valid_d[slot2_idx]   = 1'b1;
            pending_d[slot2_idx] = 1'b1;
            flushed_d[slot2_idx] = 1'b0;
            vdest_d[slot2_idx]   = req.valid_dest_2;
            lreg_d[slot2_idx]    = req.lreg_2;
            preg_d[slot2_idx]    = req.preg_2;
            ppreg_d[slot2_idx]   = req.ppreg_2;
            uop_d[slot2_idx]     = req.microoperation_2;
            pc_d[slot2_idx]      = req.pc_2;
            data_d[slot2_idx]    = '0;
        end

        if (fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + idx_t'(1);
        end

        tail_d  = tail_q + idx_t'(acc1) + idx_t'(acc2);
        count_d = count_q + cnt_t'(acc1) + cnt_t'(acc2) - cnt_t'(fire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            pending_q <= '0;
            flushed_q <= '0;
            vdest_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            for (int i = 0; i < Depth; i++) begin
                lreg_q[i]  <= '0;
                preg_q[i]  <= '0;
                ppreg_q[i] <= '0;
                uop_q[i]   <= '0;
                pc_q[i]    <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            pending_q <= pending_d;
            flushed_q <= flushed_d;
            vdest_q   <= vdest_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            lreg_q    <= lreg_d;
            preg_q    <= preg_d;
            ppreg_q   <= ppreg_d;
            uop_q     <= uop_d;
            pc_q      <= pc_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        rob_if.commit_o = '0;
        if (head_ready) begin
            rob_if.commit_o.valid_commit = 1'b1;
            rob_if.commit_o.valid_write  = vdest_q[head_q] && !flushed_q[head_q];
            rob_if.commit_o.flushed      = flushed_q[head_q];
            rob_if.commit_o.ldst         = lreg_q[head_q];
            rob_if.commit_o.pdst         = preg_q[head_q];
            rob_if.commit_o.ppdst        = ppreg_q[head_q];
            rob_if.commit_o.ticket       = head_q;
            rob_if.commit_o.pc           = pc_q[head_q];
            rob_if.commit_o.data         = data_q[head_q];
        end
    end

    always_comb begin
        rob_if.issue_o           = '0;
        rob_if.issue_o.is_full   = (count_q == cnt_t'(Depth));
        rob_if.issue_o.two_empty = (count_q <= cnt_t'(Depth - 2));
        rob_if.issue_o.ticket    = tail_q;
    end

    // Micro-op is carried for downstream debug only; exception fields are reserved.
    always_comb begin
        unused_uop = '0;
        for (int i = 0; i < Depth; i++) begin
            unused_uop = unused_uop ^ uop_q[i];
        end
    end
    assign unused_ex = ^{ex.valid_exception, ex.cause};

    req_within_capacity: assert property (@(posedge clk) disable iff (!rst_n)
        (cnt_t'(req1) + cnt_t'(req2)) <= free)
        else $error("rr_rob_commit: allocation request exceeds free entries, dropped");

endmodule
